// File: rtl/roi_acc_sched_if.sv
// Bundle of requester, operand and result signals for roi_acc_sched.
//   req/req_len   : per-requester job request and length
//   gnt           : one-hot grant, held for the whole job
//   op_*          : per-requester operand stream (valid/ready)
//   res_*         : result channel (valid/ready) with owner index
// master = requester/consumer side, slave = scheduler side.
interface roi_acc_sched_if #(
  parameter int DIN_N = 8,
  parameter int NREQ  = 4,
  parameter int LEN_W = 4,
  parameter int ID_W  = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ-1:0]       gnt;
  logic [NREQ*DIN_N-1:0] op_data;
  logic [NREQ-1:0]       op_valid;
  logic [NREQ-1:0]       op_ready;
  logic [DIN_N-1:0]      res_data;
  logic [ID_W-1:0]       res_id;
  logic                  res_valid;
  logic                  res_ready;

  modport master (
    output req, req_len, op_data, op_valid, res_ready,
    input  gnt, op_ready, res_data, res_id, res_valid
  );

  modport slave (
    input  req, req_len, op_data, op_valid, res_ready,
    output gnt, op_ready, res_data, res_id, res_valid
  );
endinterface

// File: rtl/roi_acc_sched.sv
// Round-robin accumulation scheduler. Grants one requester at a time,
// accumulates req_len operands from it (modulo 2^DIN_N) and returns the
// sum tagged with the requester index.
// Ports: clk, rst_n (async, active-low), bus (roi_acc_sched_if.slave),
//        busy (high whenever a job is in progress).
//
// state | meaning
// IDLE  | no job; arbitrating over req from rr_ptr
// ACC   | accepting operands from the granted requester
// RES   | result presented, waiting for res_ready
module roi_acc_sched #(
  parameter int DIN_N = 8,
  parameter int NREQ  = 4,
  parameter int LEN_W = 4,
  parameter int ID_W  = 2   // must equal $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  roi_acc_sched_if.slave  bus,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ACC, RES} state_t;

  state_t            state, state_nxt;
  logic [DIN_N-1:0]  acc;
  logic [LEN_W-1:0]  cnt;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   rr_ptr;

  logic              found;
  logic [ID_W-1:0]   pick;
  logic [LEN_W-1:0]  pick_len;
  logic              accept;

  // First pending request at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  assign pick_len = bus.req_len[pick*LEN_W +: LEN_W];
  assign accept   = (state == ACC) && bus.op_valid[id_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Outputs are decoded from registered state so reset clears them at once.
  always_comb begin
    state_nxt     = state;
    busy          = (state != IDLE);
    bus.gnt       = '0;
    bus.op_ready  = '0;
    bus.res_valid = 1'b0;
    bus.res_data  = acc;
    bus.res_id    = id_q;
    if (state != IDLE) bus.gnt = NREQ'(1) << id_q;
    case (state)
      IDLE: if (found) state_nxt = (pick_len == '0) ? RES : ACC;
      ACC: begin
        bus.op_ready = bus.gnt;
        if (accept && cnt == LEN_W'(1)) state_nxt = RES;
      end
      RES: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      id_q   <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          id_q <= pick;
          cnt  <= pick_len;
          acc  <= '0;
        end
        ACC: if (accept) begin
          acc <= acc + bus.op_data[id_q*DIN_N +: DIN_N];
          cnt <= cnt - LEN_W'(1);
        end
        RES: if (bus.res_ready)
          rr_ptr <= (id_q == ID_W'(NREQ-1)) ? '0 : id_q + ID_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_roi_acc_sched.sv
module tb_roi_acc_sched;
  localparam int DIN_N = 8;
  localparam int NREQ  = 4;
  localparam int LEN_W = 4;
  localparam int ID_W  = 2;

  logic clk;
  logic rst_n;
  logic busy;
  int   n_chk;
  int   n_fail;

  roi_acc_sched_if #(.DIN_N(DIN_N), .NREQ(NREQ), .LEN_W(LEN_W), .ID_W(ID_W)) bus ();

  roi_acc_sched #(.DIN_N(DIN_N), .NREQ(NREQ), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input string tag, input logic [NREQ-1:0] exp);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.gnt != '0) break;
    end
    chk(tag, 32'(bus.gnt), 32'(exp));
  endtask

  task automatic feed(input int id, input logic [DIN_N-1:0] v);
    bus.op_valid = '0;
    bus.op_valid[id] = 1'b1;
    bus.op_data[id*DIN_N +: DIN_N] = v;
    @(negedge clk);
    bus.op_valid = '0;
  endtask

  task automatic handshake(input string tag);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic set_len(input int id, input logic [LEN_W-1:0] l);
    bus.req_len[id*LEN_W +: LEN_W] = l;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.req = '0;
    bus.req_len = '0;
    bus.op_data = '0;
    bus.op_valid = '0;
    bus.res_ready = 1'b0;
    #1;
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_op_ready", 32'(bus.op_ready), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_res_data", 32'(bus.res_data), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_req_gnt", 32'(bus.gnt), 0);

    // single job: 5+7+9
    bus.req = 4'b0001;
    set_len(0, 3);
    wait_gnt("single_gnt", 4'b0001);
    chk("single_op_ready", 32'(bus.op_ready), 32'h1);
    bus.req = '0;
    feed(0, 5); feed(0, 7); feed(0, 9);
    chk("single_res_valid", 32'(bus.res_valid), 1);
    chk("single_res_data", 32'(bus.res_data), 21);
    chk("single_res_id", 32'(bus.res_id), 0);
    chk("single_op_ready_off", 32'(bus.op_ready), 0);
    handshake("single_idle");

    // reset so round robin starts from 0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 4'b1111;
    bus.req_len = 16'h1111;
    bus.op_data = {8'd40, 8'd30, 8'd20, 8'd10};
    bus.op_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt("rr_gnt", 4'(1 << (k % 4)));
      chk("rr_op_ready", 32'(bus.op_ready), 32'(1 << (k % 4)));
      @(negedge clk);
      chk("rr_res_valid", 32'(bus.res_valid), 1);
      chk("rr_res_data", 32'(bus.res_data), 32'(10 * ((k % 4) + 1)));
      chk("rr_res_id", 32'(bus.res_id), 32'(k % 4));
      handshake("rr_idle");
    end
    bus.op_valid = '0;
    bus.req = '0;

    // wrap: 200+100 mod 256, length change after grant ignored
    bus.req = 4'b0001;
    set_len(0, 2);
    wait_gnt("wrap_gnt", 4'b0001);
    set_len(0, 5);
    feed(0, 200); feed(0, 100);
    chk("wrap_res_valid", 32'(bus.res_valid), 1);
    chk("wrap_res_data", 32'(bus.res_data), 44);
    handshake("wrap_idle");
    bus.req = '0;

    // backpressure on operands and result, other requests ignored
    bus.req = 4'b0010;
    set_len(1, 3);
    wait_gnt("bp_gnt", 4'b0010);
    bus.req = 4'b1101;
    feed(1, 50);
    bus.op_data[1*DIN_N +: DIN_N] = 8'd99;
    @(negedge clk);
    chk("bp_op_ready_held", 32'(bus.op_ready), 32'h2);
    feed(1, 60);
    @(negedge clk);
    chk("bp_gnt_held", 32'(bus.gnt), 32'h2);
    feed(1, 70);
    bus.req = '0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_res_valid", 32'(bus.res_valid), 1);
      chk("bp_res_data", 32'(bus.res_data), 180);
      chk("bp_res_id", 32'(bus.res_id), 1);
      chk("bp_res_gnt", 32'(bus.gnt), 32'h2);
      @(negedge clk);
    end
    handshake("bp_idle");

    // zero length job
    bus.req = 4'b0100;
    set_len(2, 0);
    wait_gnt("zero_gnt", 4'b0100);
    bus.req = '0;
    chk("zero_op_ready", 32'(bus.op_ready), 0);
    chk("zero_res_valid", 32'(bus.res_valid), 1);
    chk("zero_res_data", 32'(bus.res_data), 0);
    chk("zero_res_id", 32'(bus.res_id), 2);
    handshake("zero_idle");

    // reset mid-job after 2 of 4 operands
    bus.req = 4'b0001;
    set_len(0, 4);
    wait_gnt("mid_gnt", 4'b0001);
    feed(0, 11); feed(0, 22);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(bus.gnt), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_op_ready", 32'(bus.op_ready), 0);
    chk("mid_rst_res_valid", 32'(bus.res_valid), 0);
    chk("mid_rst_res_data", 32'(bus.res_data), 0);
    chk("mid_rst_res_id", 32'(bus.res_id), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 4'b1010;
    set_len(1, 2);
    set_len(3, 1);
    wait_gnt("post_rst_gnt", 4'b0010);
    bus.req = '0;
    feed(1, 3); feed(1, 4);
    chk("post_rst_res_valid", 32'(bus.res_valid), 1);
    chk("post_rst_res_data", 32'(bus.res_data), 7);
    chk("post_rst_res_id", 32'(bus.res_id), 1);
    handshake("post_rst_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
